// File: rtl/skid_fifo_if.sv
// Handshake bundle for skid_fifo: upstream push channel, downstream pop channel,
// flush and occupancy status. The FIFO takes the slave side.
interface skid_fifo_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic             flush;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic [LVL_W-1:0] level;
    logic             almost_full;

    modport slave (
        input  flush, s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, level, almost_full
    );

    modport master (
        output flush, s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, level, almost_full
    );
endinterface

// File: rtl/skid_fifo.sv
// First-word fall-through FIFO with registered handshake flags, a separately
// tracked level counter, synchronous flush and synchronous active-high reset.
module skid_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int AF_THRESH = DEPTH - 1
) (
    input  logic        clk,
    input  logic        srst,
    skid_fifo_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] AF_LVL   = LVL_W'(AF_THRESH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             s_ready_q, s_ready_d;
    logic             m_valid_q, m_valid_d;
    logic             af_q, af_d;
    logic             push, pop;

    // Handshakes qualify on the registered flags so no input reaches an output.
    assign push = bus.s_valid && s_ready_q;
    assign pop  = m_valid_q && bus.m_ready;

    // NOTE: combinational next-state uses blocking '=' with every output
    // defaulted first so no latch is inferred; state below uses '<=' only.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
        m_valid_d = (level_d != '0);
        s_ready_d = (level_d != FULL_LVL);
        af_d      = (level_d >= AF_LVL);
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            m_valid_q <= 1'b0;
            s_ready_q <= 1'b1;
            af_q      <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            m_valid_q <= m_valid_d;
            s_ready_q <= s_ready_d;
            af_q      <= af_d;
        end
    end

    // NOTE: storage is deliberately not reset; m_data is masked to zero while
    // empty, so stale contents are never observable.
    always_ff @(posedge clk) begin
        if (push && !bus.flush && !srst) begin
            mem_q[wr_ptr_q] <= bus.s_data;
        end
    end

    assign bus.m_data      = m_valid_q ? mem_q[rd_ptr_q] : '0;
    assign bus.m_valid     = m_valid_q;
    assign bus.s_ready     = s_ready_q;
    assign bus.level       = level_q;
    assign bus.almost_full = af_q;
endmodule

// File: tb/tb_skid_fifo.sv
// Randomized and directed bench for skid_fifo, compared every cycle against
// a queue-based reference model.
module tb_skid_fifo;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int AF    = DEPTH - 1;

    logic clk = 1'b0;
    logic srst;
    always #5 clk = ~clk;

    skid_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    skid_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF)) dut (
        .clk (clk),
        .srst(srst),
        .bus (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of stored words.
    logic [WIDTH-1:0] model_q[$];
    logic [WIDTH-1:0] popped;
    bit               model_on = 1'b0;
    bit               do_push, do_pop;

    always @(posedge clk) begin
        if (srst) begin
            model_q.delete();
            model_on = 1'b1;
        end else if (model_on) begin
            if (bus.flush) begin
                model_q.delete();
            end else begin
                do_pop  = bus.m_ready && (model_q.size() > 0);
                do_push = bus.s_valid && (model_q.size() < DEPTH);
                if (do_pop)  popped = model_q.pop_front();
                if (do_push) model_q.push_back(bus.s_data);
            end
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            check("m_valid", 32'(bus.m_valid), 32'(model_q.size() != 0));
            check("s_ready", 32'(bus.s_ready), 32'(model_q.size() != DEPTH));
            check("level", 32'(bus.level), 32'(model_q.size()));
            check("almost_full", 32'(bus.almost_full), 32'(model_q.size() >= AF));
            check("m_data", 32'(bus.m_data), (model_q.size() != 0) ? 32'(model_q[0]) : 32'h0);
            check("level_bound", 32'(bus.level <= 3'(DEPTH)), 32'h1);
        end
    end

    task automatic drive(input logic rs, input logic fl, input logic sv,
                         input logic [WIDTH-1:0] sd, input logic mr);
        srst        = rs;
        bus.flush   = fl;
        bus.s_valid = sv;
        bus.s_data  = sd;
        bus.m_ready = mr;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_level"}, 32'(bus.level), 32'h0);
        check({tag, "_m_valid"}, 32'(bus.m_valid), 32'h0);
        check({tag, "_s_ready"}, 32'(bus.s_ready), 32'h1);
        check({tag, "_af"}, 32'(bus.almost_full), 32'h0);
        check({tag, "_m_data"}, 32'(bus.m_data), 32'h0);
    endtask

    logic [WIDTH-1:0] got[$];

    initial begin
        srst = 1'b1; bus.flush = 1'b0; bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0;
        drive(1, 0, 0, 8'h00, 0);
        drive(1, 0, 0, 8'h00, 0);
        check_reset_state("reset");

        // Three pushes with the sink stalled.
        drive(0, 0, 1, 8'h11, 0);
        drive(0, 0, 1, 8'h22, 0);
        drive(0, 0, 1, 8'h33, 0);
        check("fill3_level", 32'(bus.level), 32'h3);
        check("fill3_m_data", 32'(bus.m_data), 32'h11);
        check("fill3_af", 32'(bus.almost_full), 32'h1);
        check("fill3_s_ready", 32'(bus.s_ready), 32'h1);

        // Reset beats flush, push and pop on the same edge.
        drive(1, 1, 1, 8'h99, 1);
        check_reset_state("srst_prio");

        // Fill to full, offer an extra word, then drain.
        for (int i = 0; i < DEPTH; i++) drive(0, 0, 1, 8'hA0 + 8'(i), 0);
        check("full_s_ready", 32'(bus.s_ready), 32'h0);
        check("full_level", 32'(bus.level), 32'h4);
        drive(0, 0, 1, 8'hFF, 0);
        check("full_ignore_level", 32'(bus.level), 32'h4);
        check("full_ignore_head", 32'(bus.m_data), 32'hA0);
        got.delete();
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_m_valid", 32'(bus.m_valid), 32'h1);
            got.push_back(bus.m_data);
            drive(0, 0, 0, 8'h00, 1);
            if (i == 0) check("after_full_pop_s_ready", 32'(bus.s_ready), 32'h1);
        end
        for (int i = 0; i < DEPTH; i++) check("drain_order", 32'(got[i]), 32'hA0 + 32'(i));
        check("drained_m_valid", 32'(bus.m_valid), 32'h0);
        check("drained_m_data", 32'(bus.m_data), 32'h0);

        // Continuous streaming with both sides always ready.
        drive(1, 0, 0, 8'h00, 0);
        got.delete();
        for (int i = 0; i < 20; i++) begin
            if (bus.m_valid) got.push_back(bus.m_data);
            drive(0, 0, 1, 8'(i), 1);
            check("stream_level", 32'(bus.level), 32'h1);
        end
        check("stream_count", 32'(got.size()), 32'd19);
        for (int k = 0; k < got.size(); k++) check("stream_value", 32'(got[k]), 32'(k));

        // Flush at level 2 with a simultaneous push of 0x55.
        drive(1, 0, 0, 8'h00, 0);
        drive(0, 0, 1, 8'h01, 0);
        drive(0, 0, 1, 8'h02, 0);
        check("preflush_level", 32'(bus.level), 32'h2);
        drive(0, 1, 1, 8'h55, 0);
        check_reset_state("flush");
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 8'h00, 1);
            check("postflush_m_valid", 32'(bus.m_valid), 32'h0);
            check("postflush_m_data", 32'(bus.m_data), 32'h0);
        end

        // Random traffic at 50% duty with rare flushes and resets.
        drive(1, 0, 0, 8'h00, 0);
        for (int i = 0; i < 10000; i++) begin
            drive(($urandom % 1000) == 0, ($urandom % 256) == 0,
                  1'($urandom % 2), 8'($urandom), 1'($urandom % 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/skid_fifo.md
SKID_FIFO -- requirements
Module: skid_fifo

Interface
REQ-001 Parameter WIDTH, 8, payload width in bits; SHALL be >= 1.
REQ-002 Parameter DEPTH, 4, storage entries; SHALL be a power of two and >= 2.
REQ-003 Parameter AF_THRESH, DEPTH-1, level at or above which almost_full asserts; SHALL be 1..DEPTH.
REQ-004 Port clk  input  1  clock; all state SHALL update on its rising edge only.
REQ-005 Port srst  input  1  reset, synchronous, active-high.
REQ-006 Port flush  input  1  synchronous discard of all stored entries.
REQ-007 Port s_valid  input  1  upstream data valid.
REQ-008 Port s_ready  output  1  block can accept a word.
REQ-009 Port s_data  input  WIDTH  upstream payload.
REQ-010 Port m_valid  output  1  m_data holds a valid word.
REQ-011 Port m_ready  input  1  downstream accepts a word.
REQ-012 Port m_data  output  WIDTH  head-of-queue payload.
REQ-013 Port level  output  $clog2(DEPTH+1)  count of stored words.
REQ-014 Port almost_full  output  1  level >= AF_THRESH.

Function
REQ-015 Push SHALL occur on an edge where s_valid && s_ready; pop SHALL occur on an edge where m_valid && m_ready.
REQ-016 Operation SHALL be first-word fall-through: m_data SHALL equal the oldest stored word whenever m_valid=1, with no extra read cycle.
REQ-017 m_valid SHALL equal (level != 0); s_ready SHALL equal (level != DEPTH).
REQ-018 s_ready, m_valid, m_data, level and almost_full SHALL depend only on registered state; no combinational path SHALL exist from any input to any output.
REQ-019 Latency: a word pushed on edge N SHALL appear on m_data with m_valid=1 after edge N if the queue was empty; there is no same-cycle bypass from s_data to m_data.
REQ-020 Empty: m_valid=0; m_ready SHALL be ignored; m_data SHALL be all-zero.
REQ-021 Full: s_ready=0; s_valid and s_data SHALL be ignored; no stored word SHALL be overwritten.
REQ-022 Simultaneous push and pop with 0 < level < DEPTH SHALL leave level unchanged and preserve order.
REQ-023 Push at full with simultaneous pop SHALL NOT occur, because s_ready=0 at full; after the pop, s_ready SHALL be 1 on the following cycle.
REQ-024 Read/write pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH; level SHALL be tracked separately and never wrap.
REQ-025 level SHALL increment by 1 on push-only, decrement by 1 on pop-only, and be unchanged otherwise.
REQ-026 Word order out SHALL equal word order in; no word SHALL be dropped or duplicated.
REQ-027 flush=1 on an edge SHALL set level=0 and both pointers to 0, and SHALL discard any push or pop occurring on the same edge.
REQ-028 Stored payload SHALL be held stable while not popped, including while m_ready=0 for any number of cycles.

Reset
REQ-029 srst=1 on an edge SHALL set level=0, both pointers to 0, m_valid=0, s_ready=1 (after that edge), almost_full=0 and m_data=0.
REQ-030 srst SHALL take priority over flush, push and pop, including mid-stream with a partially full queue.
REQ-031 Storage contents need not be cleared by srst, but m_data SHALL read 0 while empty.

Verification
REQ-032 Reset, then push 0x11,0x22,0x33 with m_ready=0 -> level=3, m_data=0x11, almost_full=1 at DEPTH=4.
REQ-033 Fill a DEPTH=4 queue with 0xA0..0xA3 -> s_ready=0; a further s_valid with 0xFF is ignored; drain -> output sequence A0,A1,A2,A3, then m_valid=0.
REQ-034 Hold s_valid=1 and m_ready=1 for 20 cycles with an incrementing payload starting at 0 -> one word out per cycle after the first, output values 0..18 in order, level constant at 1.
REQ-035 Assert flush at level=2 with a simultaneous push of 0x55 -> level=0, m_valid=0, s_ready=1 on the next cycle, and 0x55 is never output.
REQ-036 Assert srst at level=3 with simultaneous flush, push and pop -> all outputs at their reset values on the next cycle.
REQ-037 Run random s_valid/m_ready (50% duty) for 10k cycles against a scoreboard model -> no loss, duplication or reorder; level always <= DEPTH; pointers wrap correctly.
